// File: rtl/mag_serializer.sv
// mag_serializer: captures a parallel frame of bin magnitudes, updates a
// per-bin decaying peak-hold, and streams the bins out one per handshake.
module mag_serializer #(
    parameter int WIDTH       = 12,
    parameter int N           = 256,
    parameter int DECAY_SHIFT = 3
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [0:N-1][WIDTH+1:0]        magnitude,
    input  logic                           frame_valid,
    output logic                           frame_ready,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [$clog2(N)-1:0]           out_bin,
    output logic [WIDTH+1:0]               out_mag,
    output logic [WIDTH+1:0]               out_peak,
    output logic                           out_last
);

    localparam int unsigned MW    = WIDTH + 2;
    localparam int unsigned IDX_W = $clog2(N);
    localparam int unsigned NB    = N;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] idx;
    logic [MW-1:0]    buf_mag [N];
    logic [MW-1:0]    peak    [N];
    logic             capture;
    logic             transfer;

    // Decayed peak never underflows: a non-zero peak drops by at least 1.
    function automatic logic [MW-1:0] next_peak(input logic [MW-1:0] cur,
                                                 input logic [MW-1:0] in);
        logic [MW-1:0] step;
        logic [MW-1:0] decayed;
        step = cur >> DECAY_SHIFT;
        if (step == '0)
            step = MW'(1);
        decayed = (cur == '0) ? '0 : cur - step;
        return (in > decayed) ? in : decayed;
    endfunction

    // State register.
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next-state, handshake and output decode; rst forces all outputs low.
    always_comb begin
        state_next  = state;
        frame_ready = 1'b0;
        out_valid   = 1'b0;
        out_last    = 1'b0;
        capture     = 1'b0;
        transfer    = 1'b0;
        case (state)
            IDLE: begin
                frame_ready = !rst;
                capture     = frame_valid && !rst;
                if (capture)
                    state_next = STREAM;
            end
            STREAM: begin
                out_valid = !rst;
                out_last  = !rst && (idx == LAST_IDX);
                transfer  = out_valid && out_ready;
                if (transfer && idx == LAST_IDX)
                    state_next = IDLE;
            end
        endcase
        out_bin  = rst ? '0 : idx;
        out_mag  = rst ? '0 : buf_mag[idx];
        out_peak = rst ? '0 : peak[idx];
    end

    // Beat index: cleared on capture, advances on each accepted beat.
    always_ff @(posedge clk) begin
        if (rst)
            idx <= '0;
        else if (capture)
            idx <= '0;
        else if (transfer)
            idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
    end

    // Frame buffer and peak-hold, both written only on capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NB; i++) begin
                buf_mag[IDX_W'(i)] <= '0;
                peak[IDX_W'(i)]    <= '0;
            end
        end else if (capture) begin
            for (int unsigned i = 0; i < NB; i++) begin
                buf_mag[IDX_W'(i)] <= magnitude[IDX_W'(i)];
                peak[IDX_W'(i)]    <= next_peak(peak[IDX_W'(i)], magnitude[IDX_W'(i)]);
            end
        end
    end

endmodule

// File: tb/tb_mag_serializer.sv
// tb_mag_serializer: randomized and directed stimulus against a queue-based
// model of the beat stream, plus hand-computed checks that pin the model.
module tb_mag_serializer;

    localparam int WIDTH = 12;
    localparam int N     = 256;
    localparam int MW    = WIDTH + 2;
    localparam int IW    = 8;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    frame_valid = 1'b0;
    logic                    out_ready = 1'b0;
    logic [0:N-1][MW-1:0]    magnitude = '0;
    logic                    frame_ready;
    logic                    out_valid;
    logic                    out_last;
    logic [IW-1:0]           out_bin;
    logic [MW-1:0]           out_mag;
    logic [MW-1:0]           out_peak;

    int vectors = 0;
    int miscompares = 0;
    int beats = 0;
    int lasts = 0;
    int seen_mag [N];
    int seen_peak [N];
    int saved_mag [N];

    always #5 clk = ~clk;

    mag_serializer #(
        .WIDTH(WIDTH),
        .N(N),
        .DECAY_SHIFT(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .magnitude(magnitude),
        .frame_valid(frame_valid),
        .frame_ready(frame_ready),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_bin(out_bin),
        .out_mag(out_mag),
        .out_peak(out_peak),
        .out_last(out_last)
    );

    // Reference model: a captured frame becomes a queue of N pending beats.
    typedef struct {
        int bin;
        int mag;
        int peak;
    } beat_t;

    beat_t q[$];
    int    mpeak [N];

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            for (int i = 0; i < N; i++) mpeak[i] = 0;
        end else if (q.size() != 0) begin
            if (out_ready) q.delete(0);
        end else if (frame_valid) begin
            for (int i = 0; i < N; i++) begin
                int m;
                int dec;
                m = int'(magnitude[i]);
                if (mpeak[i] == 0) dec = 0;
                else dec = mpeak[i] - ((mpeak[i] / 8 > 0) ? mpeak[i] / 8 : 1);
                mpeak[i] = (m > dec) ? m : dec;
                q.push_back('{i, m, mpeak[i]});
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_valid", 32'(out_valid), 0);
            chk("rst_ready", 32'(frame_ready), 0);
            chk("rst_last", 32'(out_last), 0);
            chk("rst_bin", 32'(out_bin), 0);
            chk("rst_mag", 32'(out_mag), 0);
            chk("rst_peak", 32'(out_peak), 0);
        end else if (q.size() != 0) begin
            chk("valid", 32'(out_valid), 1);
            chk("ready_stream", 32'(frame_ready), 0);
            chk("bin", 32'(out_bin), q[0].bin);
            chk("mag", 32'(out_mag), q[0].mag);
            chk("peak", 32'(out_peak), q[0].peak);
            chk("last", 32'(out_last), 32'(q[0].bin == N - 1));
        end else begin
            chk("valid_idle", 32'(out_valid), 0);
            chk("ready_idle", 32'(frame_ready), 1);
            chk("last_idle", 32'(out_last), 0);
        end
        if (!rst && out_valid && out_ready) begin
            beats++;
            if (out_last) lasts++;
            seen_mag[out_bin]  = int'(out_mag);
            seen_peak[out_bin] = int'(out_peak);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame();
        beats = 0;
        lasts = 0;
        frame_valid = 1'b1;
        tick();
        frame_valid = 1'b0;
    endtask

    // mode 0: ready held high, 1: repeating 1,0,0,1, 2: random
    task automatic stream(input int mode);
        int n;
        n = 0;
        while (!frame_ready && n < 3000) begin
            case (mode)
                0: out_ready = 1'b1;
                1: out_ready = (n % 4 == 0) || (n % 4 == 3);
                default: out_ready = 1'($urandom);
            endcase
            tick();
            n++;
        end
        if (!frame_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL stream_timeout: frame_ready still %0d after %0d cycles", frame_ready, n);
        end
        chk("beat_count", beats, N);
        chk("last_count", lasts, 1);
    endtask

    task automatic rand_mags();
        for (int i = 0; i < N; i++) magnitude[i] = MW'($urandom);
    endtask

    initial begin
        int e5 [4];
        int e0 [4];
        int n;
        e5 = '{800, 700, 613, 537};
        e0 = '{3, 2, 1, 0};

        // Reset, with a frame_valid that must be ignored.
        tick();
        frame_valid = 1'b1;
        rand_mags();
        tick();
        frame_valid = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        chk("ready_after_rst", 32'(frame_ready), 1);
        chk("valid_after_rst", 32'(out_valid), 0);
        tick();

        // Ramp frame: one-cycle latency, bin = mag = peak.
        for (int i = 0; i < N; i++) magnitude[i] = MW'(i);
        out_ready = 1'b1;
        send_frame();
        #1;
        chk("latency_valid", 32'(out_valid), 1);
        chk("latency_bin", 32'(out_bin), 0);
        stream(0);
        chk("ramp_mag0", seen_mag[0], 0);
        chk("ramp_mag255", seen_mag[255], 255);
        chk("ramp_peak200", seen_peak[200], 200);

        // Backpressure 1,0,0,1.
        rand_mags();
        send_frame();
        stream(1);

        // Peak decay and decay floor from cleared peaks.
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        for (int f = 0; f < 4; f++) begin
            magnitude = '0;
            if (f == 0) begin
                magnitude[5] = MW'(800);
                magnitude[0] = MW'(3);
            end
            send_frame();
            stream(0);
            chk("decay_bin5", seen_peak[5], e5[f]);
            chk("floor_bin0", seen_peak[0], e0[f]);
        end

        // frame_valid held through STREAM with changing data.
        rand_mags();
        magnitude[3] = MW'(1023);
        out_ready = 1'b1;
        send_frame();
        frame_valid = 1'b1;
        for (int c = 0; c < 40; c++) begin
            rand_mags();
            magnitude[3] = '0;
            tick();
        end
        frame_valid = 1'b0;
        stream(0);
        chk("held_mag3", seen_mag[3], 1023);
        chk("held_peak3", seen_peak[3], 1023);

        // Random frames with random backpressure, including back-to-back.
        for (int f = 0; f < 4; f++) begin
            rand_mags();
            send_frame();
            stream(2);
        end

        // Reset at bin 100 aborts the frame and clears peaks.
        rand_mags();
        out_ready = 1'b1;
        send_frame();
        n = 0;
        while (!(out_valid && out_bin == IW'(100)) && n < 500) begin
            tick();
            n++;
        end
        chk("reached_bin100", 32'(out_bin), 100);
        rst = 1'b1;
        tick();
        chk("abort_valid", 32'(out_valid), 0);
        rst = 1'b0;
        #1;
        chk("abort_ready", 32'(frame_ready), 1);
        chk("abort_valid_after", 32'(out_valid), 0);
        tick();
        rand_mags();
        for (int i = 0; i < N; i++) saved_mag[i] = int'(magnitude[i]);
        send_frame();
        stream(0);
        chk("cleared_peak0", seen_peak[0], saved_mag[0]);
        chk("cleared_peak100", seen_peak[100], saved_mag[100]);
        chk("cleared_peak255", seen_peak[255], saved_mag[255]);

        out_ready = 1'b0;
        repeat (5) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mag_serializer.md
MAG_SERIALIZER -- requirements
Module: mag_serializer

Interface
REQ-001 Parameter WIDTH, default 12: signed FFT component width minus sign; magnitudes are WIDTH+2 bits unsigned.
REQ-002 Parameter N, default 256: bins per frame, power of two.
REQ-003 Parameter DECAY_SHIFT, default 3: peak-hold decay is peak>>DECAY_SHIFT per accepted frame.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 magnitude  input  [0:N-1][WIDTH+1:0]  parallel frame of bin magnitudes from the estimator.
REQ-007 frame_valid  input  1  magnitude holds a complete frame.
REQ-008 frame_ready  output  1  block can capture a frame this cycle.
REQ-009 out_valid  output  1  out_* fields carry a valid bin.
REQ-010 out_ready  input  1  downstream (display) accepts the current bin.
REQ-011 out_bin  output  log2(N)  bin index of current beat.
REQ-012 out_mag  output  WIDTH+2  captured magnitude of out_bin.
REQ-013 out_peak  output  WIDTH+2  peak-hold value of out_bin.
REQ-014 out_last  output  1  current beat is bin N-1.

Function
REQ-015 FSM SHALL have two states: IDLE and STREAM.
REQ-016 IDLE: frame_ready=1, out_valid=0; frame_valid=1 SHALL capture all N magnitudes into an internal buffer, set index 0, enter STREAM next cycle.
REQ-017 STREAM: frame_ready=0, out_valid=1; frame_valid SHALL be ignored (no capture, no peak update).
REQ-018 Capture at edge k SHALL yield out_valid=1 with out_bin=0 in cycle k+1 (one-cycle latency).
REQ-019 Beat transfers when out_valid & out_ready; index SHALL increment by 1 on each transfer and hold otherwise.
REQ-020 out_bin, out_mag, out_peak, out_last SHALL remain stable while out_valid=1 and out_ready=0.
REQ-021 out_last SHALL be 1 iff STREAM and index = N-1.
REQ-022 Transfer at index N-1 SHALL return to IDLE next cycle with index wrapped to 0; no beat N emitted.
REQ-023 Back-to-back: frame_valid may be captured in the first IDLE cycle after the last transfer; minimum frame period N+1 cycles with out_ready held 1.
REQ-024 On capture, per bin i: d = peak[i] - max(peak[i]>>DECAY_SHIFT, 1) if peak[i]>0, else 0; peak[i] SHALL become max(magnitude[i], d).
REQ-025 Peak arithmetic SHALL be unsigned WIDTH+2 bits; d never underflows; no saturation needed.
REQ-026 out_peak SHALL reflect peaks updated by the frame being streamed.
REQ-027 Peaks SHALL update only on capture, never during STREAM.

Reset
REQ-028 rst=1 SHALL force IDLE, index 0, all buffer and peak entries 0, out_valid=0, out_last=0, out_bin=0, out_mag=0, out_peak=0.
REQ-029 frame_ready SHALL be 0 while rst=1 and 1 in the first cycle after rst deasserts.
REQ-030 rst asserted mid-STREAM SHALL abort the frame; no further beats; peaks cleared.
REQ-031 frame_valid coincident with rst=1 SHALL be ignored.

Verification
REQ-032 Ramp frame magnitude[i]=i, out_ready=1 -> out_valid rises 1 cycle after capture; 256 beats out_bin=0..255, out_mag=i, out_peak=i, out_last only at bin 255; IDLE next cycle.
REQ-033 Backpressure: out_ready toggling 1,0,0,1 every 4 cycles -> no bin skipped or duplicated; outputs stable while stalled; 256 beats total.
REQ-034 Peak decay: bin 5 = 800 frame 1, 0 frames 2..4 -> out_peak[5] = 800, 700, 613, 537.
REQ-035 Decay floor: bin 0 = 3 then 0 for three frames -> out_peak[0] = 3, 2, 1, 0.
REQ-036 frame_valid held high during STREAM with changing magnitude -> streamed values and peaks match first captured frame only.
REQ-037 rst at bin 100 -> out_valid=0 next cycle, frame_ready=1 after release, next frame out_peak equals magnitude (peaks cleared).
